// File: rtl/rgb_pwm_capture_pkg.sv
// ============================================================================
// Module  : rgb_pwm_pkg
// Purpose : Shared types, sector codes and the hue-sector classifier for the
//           RGB PWM capture block.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rgb_pwm_pkg;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_e;

  // Classifier operand width; duty counts are zero-extended to this width,
  // which covers any PWM_PERIOD up to 65535.
  localparam int CLS_W = 16;

  localparam logic [2:0] SECT_0    = 3'd0;
  localparam logic [2:0] SECT_1    = 3'd1;
  localparam logic [2:0] SECT_2    = 3'd2;
  localparam logic [2:0] SECT_3    = 3'd3;
  localparam logic [2:0] SECT_4    = 3'd4;
  localparam logic [2:0] SECT_5    = 3'd5;
  localparam logic [2:0] SECT_GRAY = 3'd7;

  // Max picks the first of R,G,B holding the largest value; min picks the
  // first of B,G,R (excluding max) holding the smallest value.
  function automatic logic [2:0] classify(input logic [CLS_W-1:0] r,
                                          input logic [CLS_W-1:0] g,
                                          input logic [CLS_W-1:0] b);
    channel_e   mx;
    channel_e   mn;
    logic [2:0] s;
    s = SECT_GRAY;
    if (r >= g && r >= b) begin
      mx = CH_R;
      mn = (b <= g) ? CH_B : CH_G;
    end else if (g >= b) begin
      mx = CH_G;
      mn = (b <= r) ? CH_B : CH_R;
    end else begin
      mx = CH_B;
      mn = (g <= r) ? CH_G : CH_R;
    end
    case (mx)
      CH_R:    s = (mn == CH_B) ? SECT_0 : SECT_5;
      CH_G:    s = (mn == CH_B) ? SECT_1 : SECT_2;
      CH_B:    s = (mn == CH_R) ? SECT_3 : SECT_4;
      default: s = SECT_GRAY;
    endcase
    if (r == g && g == b) begin
      s = SECT_GRAY;
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_pwm_capture_if.sv
// ============================================================================
// Module  : rgb_pwm_capture_if
// Purpose : Bundles the PWM inputs and measurement outputs of rgb_pwm_capture.
// Ports   : pwm_r/g/b (to DUT), duty_r/g/b, sector, duty_valid, frame_start
//           (from DUT). master = stimulus side, slave = capture block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface rgb_pwm_capture_if #(
  parameter int PWM_PERIOD = 256
) ();
  localparam int CNT_W = $clog2(PWM_PERIOD + 1);

  logic             pwm_r;
  logic             pwm_g;
  logic             pwm_b;
  logic [CNT_W-1:0] duty_r;
  logic [CNT_W-1:0] duty_g;
  logic [CNT_W-1:0] duty_b;
  logic [2:0]       sector;
  logic             duty_valid;
  logic             frame_start;

  modport master (
    output pwm_r, pwm_g, pwm_b,
    input  duty_r, duty_g, duty_b, sector, duty_valid, frame_start
  );

  modport slave (
    input  pwm_r, pwm_g, pwm_b,
    output duty_r, duty_g, duty_b, sector, duty_valid, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/rgb_pwm_capture_duty_meter.sv
// ============================================================================
// Module  : pwm_duty_meter
// Purpose : Synchronizes one PWM line and counts its high cycles per frame.
// Ports   : clk, rst_n          clock, async active-low reset
//           i_pwm_in            asynchronous PWM line
//           i_frame_first       high on frame_cnt == 0
//           i_frame_last        high on frame_cnt == PWM_PERIOD-1
//           o_final             running count including this cycle's sample
//           o_duty              registered count of the last completed frame
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_duty_meter #(
  parameter int PWM_PERIOD  = 256,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W      = $clog2(PWM_PERIOD + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             i_pwm_in,
  input  wire logic             i_frame_first,
  input  wire logic             i_frame_last,
  output logic      [CNT_W-1:0] o_final,
  output logic      [CNT_W-1:0] o_duty
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_hi;
  logic [CNT_W-1:0]       r_duty;
  logic [CNT_W-1:0]       w_inc;
  logic [CNT_W-1:0]       w_final;

  assign w_inc   = {{(CNT_W-1){1'b0}}, r_sync[SYNC_STAGES-1]};
  assign w_final = r_hi + w_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hi   <= '0;
      r_duty <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
      // First cycle of a frame restarts the count with its own sample.
      r_hi   <= i_frame_first ? w_inc : w_final;
      if (i_frame_last) begin
        r_duty <= w_final;
      end
    end
  end

  assign o_final = w_final;
  assign o_duty  = r_duty;

endmodule

`default_nettype wire

// File: rtl/rgb_pwm_capture.sv
// ============================================================================
// Module  : rgb_pwm_capture
// Purpose : Measures R/G/B PWM duty over fixed frames and classifies the
//           recovered colour into an HSV hue sector.
// Ports   : clk, rst_n   clock, async active-low reset
//           bus (slave)  pwm_r/g/b in; duty_r/g/b, sector, duty_valid,
//                        frame_start out
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_pwm_capture
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_PERIOD  = 256,
  parameter int SYNC_STAGES = 2
) (
  input wire logic      clk,
  input wire logic      rst_n,
  rgb_pwm_capture_if.slave bus
);

  localparam int CNT_W = $clog2(PWM_PERIOD + 1);
  localparam int FC_W  = $clog2(PWM_PERIOD);
  localparam logic [FC_W-1:0] c_LAST = FC_W'(PWM_PERIOD - 1);

  logic [FC_W-1:0]  r_frame_cnt;
  logic [2:0]       r_sector;
  logic             r_valid;
  logic             w_first;
  logic             w_last;
  logic [2:0]       w_pwm;
  logic [2:0]       w_sector;
  logic [CNT_W-1:0] w_final [3];
  logic [CNT_W-1:0] w_duty  [3];

  assign w_first = (r_frame_cnt == '0);
  assign w_last  = (r_frame_cnt == c_LAST);
  assign w_pwm   = {bus.pwm_b, bus.pwm_g, bus.pwm_r};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      pwm_duty_meter #(
        .PWM_PERIOD  (PWM_PERIOD),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_meter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pwm_in      (w_pwm[gi]),
        .i_frame_first (w_first),
        .i_frame_last  (w_last),
        .o_final       (w_final[gi]),
        .o_duty        (w_duty[gi])
      );
    end
  endgenerate

  // Classified from the closing counts so sector lands together with duty_*.
  assign w_sector = classify(CLS_W'(w_final[0]), CLS_W'(w_final[1]),
                             CLS_W'(w_final[2]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_sector    <= SECT_GRAY;
      r_valid     <= 1'b0;
    end else begin
      r_frame_cnt <= w_last ? '0 : r_frame_cnt + 1'b1;
      r_valid     <= w_last;
      if (w_last) begin
        r_sector <= w_sector;
      end
    end
  end

  assign bus.duty_r      = w_duty[0];
  assign bus.duty_g      = w_duty[1];
  assign bus.duty_b      = w_duty[2];
  assign bus.sector      = r_sector;
  assign bus.duty_valid  = r_valid;
  assign bus.frame_start = w_first;

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_capture.sv
`default_nettype none

module tb_rgb_pwm_capture;

  localparam int P = 100;

  typedef struct {
    logic [6:0] r;
    logic [6:0] g;
    logic [6:0] b;
    logic [2:0] s;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;
  bit   gen_on;
  int   gen_cnt;
  int   dr, dg, db;
  exp_t q[$];

  rgb_pwm_capture_if #(.PWM_PERIOD(P)) bus ();

  rgb_pwm_capture #(.PWM_PERIOD(P), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: returns 1 time unit after the rising edge, having driven the
  // next input values from the free-running generator model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (gen_on) begin
      bus.pwm_r = (gen_cnt < dr);
      bus.pwm_g = (gen_cnt < dg);
      bus.pwm_b = (gen_cnt < db);
      gen_cnt   = (gen_cnt == P - 1) ? 0 : gen_cnt + 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < P + 50; i++) begin
      tick();
      if (bus.duty_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({bus.duty_r, bus.duty_g, bus.duty_b, bus.sector, bus.duty_valid} !==
        {7'd0, 7'd0, 7'd0, 3'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_vals: got r=%0d g=%0d b=%0d s=%0d v=%0b want 0/0/0 s=7 v=0",
               bus.duty_r, bus.duty_g, bus.duty_b, bus.sector, bus.duty_valid);
    end
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_all_zero();
    exp_t e;
    gen_on = 1'b0;
    bus.pwm_r = 0; bus.pwm_g = 0; bus.pwm_b = 0;
    do_reset();
    for (int f = 0; f < 3; f++) q.push_back('{7'd0, 7'd0, 7'd0, 3'd7});
    for (int i = 0; i < 3 * P; i++) begin
      tick();
      n_tests++;
      if (bus.duty_valid !== ((cyc % P) == 0)) begin
        n_fail++;
        $display("FAIL zero_valid_timing: cyc=%0d valid=%0b want %0b",
                 cyc, bus.duty_valid, (cyc % P) == 0);
      end
      if (bus.duty_valid === 1'b1) begin
        e = q.pop_front();
        n_tests++;
        if ({bus.duty_r, bus.duty_g, bus.duty_b, bus.sector, bus.frame_start} !==
            {e.r, e.g, e.b, e.s, 1'b1}) begin
          n_fail++;
          $display("FAIL zero_frame: got %0d/%0d/%0d s=%0d fs=%0b want %0d/%0d/%0d s=%0d fs=1",
                   bus.duty_r, bus.duty_g, bus.duty_b, bus.sector, bus.frame_start,
                   e.r, e.g, e.b, e.s);
        end
      end
    end
  endtask

  // Checks nf steady frames after skipping `skip` frames of settling.
  task automatic check_gen(input string nm, input int skip, input int nf,
                           input exp_t e_in);
    exp_t e;
    bit   ok;
    for (int f = 0; f < nf; f++) q.push_back(e_in);
    for (int f = 0; f < skip + nf; f++) begin
      wait_valid(ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s_timeout: no duty_valid within %0d cycles", nm, P + 50);
      end
      if (f >= skip) begin
        e = q.pop_front();
        n_tests++;
        if ({bus.duty_r, bus.duty_g, bus.duty_b, bus.sector} !== {e.r, e.g, e.b, e.s}) begin
          n_fail++;
          $display("FAIL %s: got %0d/%0d/%0d s=%0d want %0d/%0d/%0d s=%0d", nm,
                   bus.duty_r, bus.duty_g, bus.duty_b, bus.sector, e.r, e.g, e.b, e.s);
        end
      end
    end
  endtask

  task automatic test_all_one();
    gen_on = 1'b1;
    gen_cnt = 13;
    dr = P; dg = P; db = P;
    do_reset();
    check_gen("all_one", 1, 3, '{7'd100, 7'd100, 7'd100, 3'd7});
  endtask

  task automatic test_generator();
    gen_cnt = 37;
    dr = 50; dg = 25; db = 0;
    do_reset();
    check_gen("gen_50_25_0", 1, 3, '{7'd50, 7'd25, 7'd0, 3'd0});
  endtask

  task automatic test_sectors();
    exp_t tbl[5];
    tbl[0] = '{7'd0,  7'd60, 7'd20, 3'd2};
    tbl[1] = '{7'd0,  7'd20, 7'd60, 3'd3};
    tbl[2] = '{7'd30, 7'd0,  7'd60, 3'd4};
    tbl[3] = '{7'd60, 7'd0,  7'd30, 3'd5};
    tbl[4] = '{7'd40, 7'd40, 7'd10, 3'd0};
    // Duty changes right after a valid, so the following frame is mixed.
    for (int k = 0; k < 5; k++) begin
      dr = int'(tbl[k].r); dg = int'(tbl[k].g); db = int'(tbl[k].b);
      check_gen("sector_sweep", 1, 1, tbl[k]);
    end
  endtask

  task automatic test_edge_timing();
    gen_on = 1'b0;
    bus.pwm_r = 0; bus.pwm_g = 0; bus.pwm_b = 0;
    do_reset();
    // Pin driven after edge j is the sample at frame_cnt (j+2) mod P.
    while (cyc < 97) tick();
    bus.pwm_g = 1'b1;
    tick();
    bus.pwm_g = 1'b0;
    check_gen("edge_last", 0, 1, '{7'd0, 7'd1, 7'd0, 3'd1});
    while (cyc < 198) tick();
    bus.pwm_g = 1'b1;
    tick();
    bus.pwm_g = 1'b0;
    check_gen("edge_first_old", 0, 1, '{7'd0, 7'd0, 7'd0, 3'd7});
    check_gen("edge_first_new", 0, 1, '{7'd0, 7'd1, 7'd0, 3'd1});
  endtask

  task automatic test_mid_reset();
    int nvalid;
    gen_on = 1'b1;
    gen_cnt = 71;
    dr = 50; dg = 0; db = 0;
    do_reset();
    check_gen("pre_reset", 1, 1, '{7'd50, 7'd0, 7'd0, 3'd0});
    while ((cyc % P) != 37) tick();
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.duty_r, bus.sector, bus.duty_valid} !== {7'd0, 3'd7, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_async: got r=%0d s=%0d v=%0b want 0 s=7 v=0",
               bus.duty_r, bus.sector, bus.duty_valid);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    cyc   = 0;
    nvalid = 0;
    for (int i = 0; i < P - 1; i++) begin
      tick();
      if (bus.duty_valid === 1'b1) nvalid++;
    end
    n_tests++;
    if (nvalid != 0) begin
      n_fail++;
      $display("FAIL mid_reset_early_valid: got %0d pulses want 0", nvalid);
    end
    tick();
    n_tests++;
    if (bus.duty_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_first_valid: cyc=%0d valid=%0b want 1", cyc, bus.duty_valid);
    end
    check_gen("post_reset", 0, 1, '{7'd50, 7'd0, 7'd0, 3'd0});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    gen_on  = 1'b0;
    gen_cnt = 0;
    dr = 0; dg = 0; db = 0;
    rst_n   = 1'b0;
    bus.pwm_r = 1'b0;
    bus.pwm_g = 1'b0;
    bus.pwm_b = 1'b0;
    test_reset();
    test_all_zero();
    test_all_one();
    test_generator();
    test_sectors();
    test_edge_timing();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
